// File: rtl/mux21_arbiter_if.sv
// Two-requester / one-sink bus of the shared 2:1 datapath mux sequencer.
// The master modport is the requester+consumer side, the slave modport is the arbiter.
interface mux21_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             req_a;
    logic [WIDTH-1:0] A;
    logic             ack_a;
    logic             req_b;
    logic [WIDTH-1:0] B;
    logic             ack_b;
    logic             ctrl;
    logic [WIDTH-1:0] S;
    logic             S_valid;
    logic             S_ready;
    logic [CNT_W-1:0] xfer_cnt;

    modport master (
        output req_a, A, req_b, B, S_ready,
        input  ack_a, ack_b, ctrl, S, S_valid, xfer_cnt
    );

    modport slave (
        input  req_a, A, req_b, B, S_ready,
        output ack_a, ack_b, ctrl, S, S_valid, xfer_cnt
    );
endinterface

// File: rtl/mux21_arbiter.sv
// Round-robin 2:1 arbiter feeding one registered output word; req -> S_valid in 1 cycle, 1 word/cycle.
// Holds S until S_ready; MUX21_ARB_FIXED_PRIO_EN selects fixed priority (A wins ties).
module mux21_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    mux21_arbiter_if.slave    bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             hshake, load, grant_a, grant_b;
    logic [WIDTH-1:0] s_q, s_d;
    logic             ctrl_q, ctrl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifndef MUX21_ARB_FIXED_PRIO_EN
    logic             last_b_q, last_b_d;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (grant_a || grant_b) begin
            state_d = FULL;
        end else if (hshake) begin
            state_d = EMPTY;
        end
    end

    // Acks gated by reset so nothing is granted while rst_ni is low.
    always_comb begin
        hshake  = (state_q == FULL) && bus.S_ready;
        load    = rst_ni && ((state_q == EMPTY) || hshake);
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (load) begin
`ifdef MUX21_ARB_FIXED_PRIO_EN
            grant_a = bus.req_a;
            grant_b = bus.req_b && !bus.req_a;
`else
            grant_a = bus.req_a && (!bus.req_b || last_b_q);
            grant_b = bus.req_b && (!bus.req_a || !last_b_q);
`endif
        end
    end

    always_comb begin
        s_d    = s_q;
        ctrl_d = ctrl_q;
        if (grant_a) begin
            s_d    = bus.A;
            ctrl_d = 1'b0;
        end else if (grant_b) begin
            s_d    = bus.B;
            ctrl_d = 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(hshake);
    end

`ifndef MUX21_ARB_FIXED_PRIO_EN
    always_comb begin
        last_b_d = last_b_q;
        if (grant_a) begin
            last_b_d = 1'b0;
        end else if (grant_b) begin
            last_b_d = 1'b1;
        end
    end

    // Reset to "B granted last" so A wins the first tie.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s_q    <= '0;
            ctrl_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s_q    <= s_d;
            ctrl_q <= ctrl_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.ack_a    = grant_a;
    assign bus.ack_b    = grant_b;
    assign bus.ctrl     = ctrl_q;
    assign bus.S        = s_q;
    assign bus.S_valid  = (state_q == FULL);
    assign bus.xfer_cnt = cnt_q;
endmodule

// File: tb/tb_mux21_arbiter.sv
// Directed + random bench for mux21_arbiter against a transaction-level reference model.
// Counter width is reduced to 4 bits so wrap-around is reachable quickly.
module tb_mux21_arbiter;
    localparam int WIDTH = 32;
    localparam int CNT_W = 4;
`ifdef MUX21_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    mux21_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    mux21_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Reference model: the held word (if any), who was granted last, handshake count.
    bit          m_valid = 1'b0;
    logic [31:0] m_s     = '0;
    bit          m_ctrl  = 1'b0;
    bit          m_last_b = 1'b1;
    int          m_cnt   = 0;
    bit          saw_a, saw_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check acks before the edge, advance the model, check registers after.
    task automatic tick();
        int          winner;
        bit          ready;
        logic [31:0] a_dat, b_dat;
        #2;
        winner = 0;
        ready  = bus.S_ready;
        a_dat  = bus.A;
        b_dat  = bus.B;
        if (rst_ni && (!m_valid || ready)) begin
            if (bus.req_a && bus.req_b) winner = (FIXED || m_last_b) ? 1 : 2;
            else if (bus.req_a)         winner = 1;
            else if (bus.req_b)         winner = 2;
        end
        chk("ack_a", 32'(bus.ack_a), 32'(winner == 1));
        chk("ack_b", 32'(bus.ack_b), 32'(winner == 2));
        saw_a = (winner == 1);
        saw_b = (winner == 2);
        @(posedge clk_i);
        if (!rst_ni) begin
            m_valid = 1'b0; m_s = '0; m_ctrl = 1'b0; m_last_b = 1'b1; m_cnt = 0;
        end else begin
            if (m_valid && ready) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            if (winner != 0) begin
                m_valid  = 1'b1;
                m_s      = (winner == 1) ? a_dat : b_dat;
                m_ctrl   = (winner == 2);
                m_last_b = (winner == 2);
            end else if (m_valid && ready) begin
                m_valid = 1'b0;
            end
        end
        #1;
        chk("S", bus.S, m_s);
        chk("ctrl", 32'(bus.ctrl), 32'(m_ctrl));
        chk("S_valid", 32'(bus.S_valid), 32'(m_valid));
        chk("xfer_cnt", 32'(bus.xfer_cnt), 32'(m_cnt));
    endtask

    initial begin
        bit pa, pb;
        bus.req_a = 1'b1; bus.A = 32'h5;
        bus.req_b = 1'b0; bus.B = 32'h0;
        bus.S_ready = 1'b1;

        // Reset held for two cycles with a pending request
        rst_ni = 1'b0;
        tick(); tick();
        chk("rst_S", bus.S, 32'h0);
        chk("rst_S_valid", 32'(bus.S_valid), 32'h0);
        chk("rst_xfer_cnt", 32'(bus.xfer_cnt), 32'h0);
        rst_ni = 1'b1;
        tick();
        chk("first_grant_ack", 32'(saw_a), 32'h1);
        bus.req_a = 1'b0;
        tick();

        // Single requester
        bus.req_a = 1'b1; bus.A = 32'hDEADBEEF;
        tick();
        bus.req_a = 1'b0;
        chk("single_S", bus.S, 32'hDEADBEEF);
        chk("single_ctrl", 32'(bus.ctrl), 32'h0);
        tick();
        chk("single_cnt", 32'(bus.xfer_cnt), 32'h2);

        // Tie from a fresh reset: alternate under round-robin
        rst_ni = 1'b0; tick(); rst_ni = 1'b1;
        bus.req_a = 1'b1; bus.A = 32'h1;
        bus.req_b = 1'b1; bus.B = 32'h2;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("tie_S", bus.S, (FIXED || (i % 2 == 0)) ? 32'h1 : 32'h2);
        end

        // Backpressure with B waiting
        bus.req_a = 1'b0; bus.req_b = 1'b1; bus.B = 32'h7;
        bus.S_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        bus.S_ready = 1'b1;
        tick();
        chk("bp_ack_b", 32'(saw_b), 32'h1);
        chk("bp_S", bus.S, 32'h7);
        bus.req_b = 1'b0;
        tick();

        // Counter wrap: 17 handshakes on a 4-bit counter
        rst_ni = 1'b0; tick(); rst_ni = 1'b1;
        bus.req_a = 1'b1; bus.A = 32'h33;
        for (int i = 0; i < 18; i++) tick();
        chk("wrap_cnt", 32'(bus.xfer_cnt), 32'h1);
        bus.req_a = 1'b0;
        tick();

        // Mid-operation reset while full, with and without S_ready
        for (int v = 0; v < 2; v++) begin
            bus.S_ready = 1'b0; bus.req_a = 1'b1; bus.A = 32'h99;
            tick();
            bus.req_a = 1'b0; bus.req_b = 1'b1; bus.B = 32'h44;
            bus.S_ready = v[0];
            rst_ni = 1'b0;
            tick();
            chk("midrst_valid", 32'(bus.S_valid), 32'h0);
            chk("midrst_cnt", 32'(bus.xfer_cnt), 32'h0);
            rst_ni = 1'b1;
            bus.req_b = 1'b0; bus.S_ready = 1'b1;
            tick();
        end

        // Random traffic obeying hold-until-ack
        pa = 1'b0; pb = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pa && $urandom_range(0, 2) == 0) begin pa = 1'b1; bus.A = $urandom; end
            if (!pb && $urandom_range(0, 2) == 0) begin pb = 1'b1; bus.B = $urandom; end
            bus.req_a = pa;
            bus.req_b = pb;
            bus.S_ready = ($urandom_range(0, 3) != 0);
            rst_ni = ($urandom_range(0, 60) != 0);
            tick();
            if (saw_a) pa = 1'b0;
            if (saw_b) pb = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
